// File: rtl/game_link_pkg.sv
// Shared board-to-board ball link definitions (receiver and sender).
package game_link_pkg;

   // Receiver walks one state per received byte after SOF
   typedef enum logic [2:0] {
      IDLE,
      GET_VY,
      GET_GRAV,
      GET_SPD0,
      GET_SPD1,
      GET_SPD2,
      GET_CSUM
   } link_state_t;

   localparam logic [7:0]        SOF_BYTE      = 8'hA5;
   localparam int                FRAME_LEN     = 7;
   localparam logic [19:0]       DEFAULT_SPEED = 20'd270000;
   localparam logic signed [7:0] DEFAULT_VY    = -8'sd3;
   localparam int                GAP_CNT_W     = 15;

   // Payload bytes 1..5 exactly as they travel on the wire
   typedef struct packed {
      logic [7:0] vy;
      logic [7:0] grav;
      logic [7:0] spd0;
      logic [7:0] spd1;
      logic [7:0] spd2;
   } link_frame_t;

   // Checksum carried in the last byte: XOR of the payload bytes
   function automatic logic [7:0] frame_csum(input link_frame_t f);
      return f.vy ^ f.grav ^ f.spd0 ^ f.spd1 ^ f.spd2;
   endfunction

   // 20-bit speed divisor; upper nibble of spd2 is reserved
   function automatic logic [19:0] frame_speed(input link_frame_t f);
      return {f.spd2[3:0], f.spd1, f.spd0};
   endfunction

endpackage

// File: rtl/link_gap_timer.sv
// Inter-byte gap timer: counts idle cycles while a frame is open and
// flags expiry on the TIMEOUT_CYCLES-th consecutive idle cycle.
module link_gap_timer
   import game_link_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = 25000,
   parameter int CNT_W          = GAP_CNT_W
) (
   input  logic clk,
   input  logic reset,
   input  logic restart,
   input  logic active,
   output logic expire
);

   localparam logic [CNT_W-1:0] CNT_MAX = '1;
   localparam logic [CNT_W-1:0] LIMIT   = CNT_W'(TIMEOUT_CYCLES - 1);

   logic [CNT_W-1:0] cnt;

   // Clear on every byte or outside a frame, otherwise count up and saturate
   always_ff @(posedge clk) begin
      if (!reset)
         cnt <= '0;
      else if (restart || !active)
         cnt <= '0;
      else if (cnt != CNT_MAX)
         cnt <= cnt + CNT_W'(1);
   end

   // A byte arriving on the boundary cycle still wins over the timeout
   always_comb begin
      expire = active && !restart && (cnt >= LIMIT);
   end

endmodule

// File: rtl/ball_receive_controller.sv
// Receiving end of the ball hand-off link: assembles a 7-byte frame,
// validates it and presents the ball state through a pending/ack handshake.
module ball_receive_controller
   import game_link_pkg::*;
#(
   parameter int          TIMEOUT_CYCLES = 25000,
   parameter logic [19:0] SPEED_MAX      = DEFAULT_SPEED
) (
   input  logic        clk_25MHZ,
   input  logic        reset,
   input  logic [7:0]  rx_byte,
   input  logic        rx_valid,
   input  logic        ball_ack,
   output logic        ball_pending,
   output logic [7:0]  ball_vy,
   output logic [1:0]  gravity_counter,
   output logic [19:0] ball_speed,
   output logic        frame_error,
   output logic        overrun,
   output logic        rx_busy
);

   link_state_t state, state_next;
   link_frame_t shadow;
   logic        expire;
   logic        csum_strobe;
   logic        frame_good;
   logic        accept;
   logic        drop;
   logic [19:0] speed;

   link_gap_timer #(
      .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
      .CNT_W          (GAP_CNT_W)
   ) u_gap (
      .clk     (clk_25MHZ),
      .reset   (reset),
      .restart (rx_valid),
      .active  (state != IDLE),
      .expire  (expire)
   );

   // Frame verdict, evaluated only while the checksum byte is on the bus
   always_comb begin
      speed       = frame_speed(shadow);
      csum_strobe = rx_valid && (state == GET_CSUM);
      frame_good  = (rx_byte == frame_csum(shadow))
                 && (shadow.grav[7:2] == 6'd0)
                 && (shadow.spd2[7:4] == 4'd0)
                 && (speed != 20'd0)
                 && (speed <= SPEED_MAX);
      accept      = csum_strobe && frame_good && (!ball_pending || ball_ack);
      drop        = csum_strobe && frame_good && ball_pending && !ball_ack;
   end

   // State register
   always_ff @(posedge clk_25MHZ) begin
      if (!reset)
         state <= IDLE;
      else
         state <= state_next;
   end

   // Next state: one step per byte; a mid-frame SOF is ordinary data
   always_comb begin
      state_next = state;
      if (expire) begin
         state_next = IDLE;
      end else if (rx_valid) begin
         case (state)
            IDLE:     state_next = (rx_byte == SOF_BYTE) ? GET_VY : IDLE;
            GET_VY:   state_next = GET_GRAV;
            GET_GRAV: state_next = GET_SPD0;
            GET_SPD0: state_next = GET_SPD1;
            GET_SPD1: state_next = GET_SPD2;
            GET_SPD2: state_next = GET_CSUM;
            GET_CSUM: state_next = IDLE;
            default:  state_next = IDLE;
         endcase
      end
   end

   // FSM outputs
   always_comb begin
      rx_busy = (state != IDLE);
   end

   // Shadow capture of payload bytes as they arrive
   always_ff @(posedge clk_25MHZ) begin
      if (!reset) begin
         shadow <= '0;
      end else if (rx_valid) begin
         case (state)
            GET_VY:   shadow.vy   <= rx_byte;
            GET_GRAV: shadow.grav <= rx_byte;
            GET_SPD0: shadow.spd0 <= rx_byte;
            GET_SPD1: shadow.spd1 <= rx_byte;
            GET_SPD2: shadow.spd2 <= rx_byte;
            default:  ;
         endcase
      end
   end

   // Ball outputs and status pulses; fields change only on an accepted frame
   always_ff @(posedge clk_25MHZ) begin
      if (!reset) begin
         ball_pending    <= 1'b0;
         ball_vy         <= DEFAULT_VY;
         gravity_counter <= 2'd0;
         ball_speed      <= DEFAULT_SPEED;
         frame_error     <= 1'b0;
         overrun         <= 1'b0;
      end else begin
         frame_error <= (csum_strobe && !frame_good) || expire;
         overrun     <= drop;
         if (accept) begin
            ball_pending    <= 1'b1;
            ball_vy         <= shadow.vy;
            gravity_counter <= shadow.grav[1:0];
            ball_speed      <= speed;
         end else if (ball_ack) begin
            ball_pending <= 1'b0;
         end
      end
   end

endmodule
